// File: rtl/uart_tx_axis_pkg.sv
// ============================================================================
// Module : uart_tx_axis_pkg
// Brief  : Shared UART frame definitions: FSM encodings, parity selectors and
//          the parity helper used by the transmitter and its receiver peer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_axis_pkg;

    localparam int c_STATE_W       = 3;
    localparam int c_MAX_DATA_BITS = 9;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_PARITY = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_STOP   = 3'd4;

    localparam int c_PAR_NONE = 0;
    localparam int c_PAR_EVEN = 1;
    localparam int c_PAR_ODD  = 2;

    // Unused upper bits must be zero so they do not disturb the XOR reduction.
    function automatic logic calc_parity(input logic [c_MAX_DATA_BITS-1:0] data,
                                         input logic                       odd);
        return (^data) ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module : uart_baud_tick
// Brief  : Bit-period counter with synchronous clear; pulses bit_done on the
//          last clock of every bit period.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);
    import uart_tx_axis_pkg::*;

    localparam int                 c_CNT_W = $clog2(BAUD_DIV) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BAUD_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign bit_done = !clear && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_axis.sv
// ============================================================================
// Module : uart_tx_axis
// Brief  : UART transmitter with AXI-Stream slave input and a one-entry
//          holding register for back-to-back frames.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_axis #(
    parameter int    CLK_FREQ  = 50_000_000,
    parameter int    BAUD      = 115200,
    parameter int    DATA_BITS = 8,
    parameter string PARITY    = "even",
    parameter int    STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic                 tx,
    output logic                 tx_busy
);
    import uart_tx_axis_pkg::*;

    localparam int                 c_BAUD_DIV = CLK_FREQ / BAUD;
    localparam int                 c_BIT_W    = $clog2(DATA_BITS);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);
    localparam bit                 c_HAS_PAR  = (PARITY != "none");
    localparam logic               c_ODD      = (PARITY == "odd");

    logic [c_STATE_W-1:0] r_state;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_valid;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx;

    logic w_bit_done;
    logic w_accept;
    logic w_last_stop;
    logic w_load;

    uart_baud_tick #(
        .BAUD_DIV (c_BAUD_DIV)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (r_state == c_ST_IDLE),
        .bit_done (w_bit_done)
    );

    assign w_accept    = s_axis_tvalid && !r_hold_valid;
    assign w_last_stop = (r_state == c_ST_STOP) && w_bit_done &&
                         (r_stop_cnt == 1'(STOP_BITS - 1));
    // A pending byte starts a frame from idle, or directly after the last stop clock.
    assign w_load      = r_hold_valid && ((r_state == c_ST_IDLE) || w_last_stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_tx         <= 1'b1;
        end else begin
            if (w_accept) begin
                r_hold       <= s_axis_tdata;
                r_hold_valid <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b1;
                end
                c_ST_START: begin
                    if (w_bit_done) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_stop_cnt <= 1'b0;
                            if (c_HAS_PAR) begin
                                r_tx    <= r_par_bit;
                                r_state <= c_ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= c_ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_done) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_done) begin
                        if (w_last_stop) begin
                            r_tx    <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            endcase

            // Parity is captured from the whole byte before any shifting.
            if (w_load) begin
                r_shift      <= r_hold;
                r_par_bit    <= calc_parity(c_MAX_DATA_BITS'(r_hold), c_ODD);
                r_hold_valid <= 1'b0;
                r_tx         <= 1'b0;
                r_state      <= c_ST_START;
            end
        end
    end

    assign s_axis_tready = !r_hold_valid;
    assign tx            = r_tx;
    assign tx_busy       = (r_state != c_ST_IDLE) || r_hold_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_axis.sv
// ============================================================================
// Module : tb_uart_tx_axis
// Brief  : Scoreboard bench for uart_tx_axis with even, odd and no-parity
//          instances observed by a line-level frame monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_axis;

    localparam int DIV = 10;

    typedef struct {
        logic [11:0] bits;
        int          len;
        int          start;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] tdata_v [3];
    logic [2:0] tvalid_v;
    logic [2:0] tready_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     frames_seen [3];
    bit     in_fr [3];
    frame_t exp_q [3][$];
    int     hs_log [$];

    uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY("even"), .STOP_BITS(1)) u_dut_even (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata_v[0]), .s_axis_tvalid(tvalid_v[0]),
        .s_axis_tready(tready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]));

    uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY("odd"), .STOP_BITS(1)) u_dut_odd (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata_v[1]), .s_axis_tvalid(tvalid_v[1]),
        .s_axis_tready(tready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]));

    uart_tx_axis #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY("none"), .STOP_BITS(1)) u_dut_none (
        .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata_v[2]), .s_axis_tvalid(tvalid_v[2]),
        .s_axis_tready(tready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // 1 = even, 2 = odd, 0 = no parity
    function automatic int mode_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 0);
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, one stop bit.
    function automatic frame_t make_frame(input logic [7:0] b, input int mode);
        frame_t f;
        int     n;
        int     ones;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = b[i];
        n = 9;
        ones = $countones(b);
        if (mode != 0) begin
            f.bits[n] = (mode == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        f.len   = n;
        f.start = 0;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Watches every tx line on the falling edge; predicts handshakes for the next rising edge.
    task automatic run_monitor();
        frame_t cur [3];
        frame_t f;
        int     st [3];
        bit     bad [3];
        int     next_free [3];
        logic   prev_tx [3];
        int     p;
        int     hs;
        for (int g = 0; g < 3; g++) begin
            st[g] = 0; bad[g] = 0; next_free[g] = 0; prev_tx[g] = 1'b1; in_fr[g] = 0;
            frames_seen[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (!rst_n) begin
                    exp_q[g].delete();
                    in_fr[g]     = 0;
                    next_free[g] = 0;
                end else begin
                    if (in_fr[g]) begin
                        p = cyc - st[g];
                        if (tx_v[g] !== cur[g].bits[p / DIV]) bad[g] = 1;
                        if (p == cur[g].len * DIV - 1) begin
                            checks++;
                            if (bad[g]) begin
                                errors++;
                                $display("FAIL frame[%0d] started at edge %0d: line differs from expected bits %b len %0d",
                                         g, st[g], cur[g].bits, cur[g].len);
                            end
                            frames_seen[g]++;
                            in_fr[g] = 0;
                        end
                    end else if (exp_q[g].size() > 0 && cyc == exp_q[g][0].start) begin
                        cur[g]   = exp_q[g].pop_front();
                        st[g]    = cyc;
                        bad[g]   = 0;
                        in_fr[g] = 1;
                        chk($sformatf("start_edge[%0d]", g), {31'd0, tx_v[g]}, 32'd0);
                    end else if (tx_v[g] === 1'b0 && prev_tx[g] === 1'b1) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_start[%0d]: tx fell at edge %0d with no frame expected", g, cyc);
                    end
                    if (tvalid_v[g] && tready_v[g]) begin
                        hs = cyc + 1;
                        f = make_frame(tdata_v[g], mode_of(g));
                        f.start = (hs + 1 > next_free[g]) ? hs + 1 : next_free[g];
                        next_free[g] = f.start + f.len * DIV;
                        exp_q[g].push_back(f);
                        if (g == 0) hs_log.push_back(hs);
                    end
                end
                prev_tx[g] = tx_v[g];
            end
        end
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic send(input int g, input logic [7:0] b);
        int n;
        n = 0;
        tdata_v[g]  = b;
        tvalid_v[g] = 1'b1;
        forever begin
            @(negedge clk);
            if (tready_v[g]) break;
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout[%0d]: tready stayed %0b, required 1", g, tready_v[g]);
                break;
            end
        end
        @(posedge clk);
        #1;
        tvalid_v[g] = 1'b0;
    endtask

    task automatic wait_idle();
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
            done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0) &&
                   !in_fr[0] && !in_fr[1] && !in_fr[2] && (busy_v == 3'b000);
        end
        chk("drain_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   hs1;
        int   base;
        bit   idle_ok;
        int   g;
        logic [7:0] b;

        rst_n    = 1'b0;
        tvalid_v = 3'b000;
        for (int i = 0; i < 3; i++) tdata_v[i] = 8'h00;
        fork
            run_monitor();
        join_none

        // Reset state, including tvalid held during reset.
        repeat (2) @(posedge clk);
        #1;
        tvalid_v[0] = 1'b1;
        tdata_v[0]  = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx",     {29'd0, tx_v},     32'h7);
        chk("reset_tready", {29'd0, tready_v}, 32'h7);
        chk("reset_busy",   {29'd0, busy_v},   32'h0);
        tvalid_v[0] = 1'b0;
        rst_n = 1'b1;

        idle_ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (tx_v !== 3'b111 || busy_v !== 3'b000) idle_ok = 0;
        end
        chk("idle_after_release", {31'd0, idle_ok}, 32'd1);
        @(posedge clk);
        #1;

        // Single 0xA5 even-parity frame with exact end-of-frame timing.
        send(0, 8'hA5);
        repeat (110) @(posedge clk);
        #1;
        chk("busy_last_stop_clk", {31'd0, busy_v[0]}, 32'd1);
        @(posedge clk);
        #1;
        chk("busy_after_frame", {31'd0, busy_v[0]}, 32'd0);
        wait_idle();

        // 0x01 under the three parity modes.
        send(1, 8'h01);
        send(0, 8'h01);
        send(2, 8'h01);
        wait_idle();

        // Back-to-back pair with the second byte accepted mid-frame.
        hs_log.delete();
        send(0, 8'h55);
        send(0, 8'hAA);
        chk("tready_after_hs2", {31'd0, tready_v[0]}, 32'd0);
        chk("hs_count", hs_log.size(), 32'd2);
        if (hs_log.size() == 2) chk("hs2_spacing", hs_log[1] - hs_log[0], 32'd2);
        repeat (100) @(posedge clk);
        #1;
        chk("tready_pending", {31'd0, tready_v[0]}, 32'd0);
        chk("busy_pending",   {31'd0, busy_v[0]},   32'd1);
        wait_idle();

        // Reset during data bit 3 of 0xF0 with a byte pending.
        hs_log.delete();
        send(0, 8'hF0);
        hs1 = cyc;
        send(0, 8'h33);
        repeat (42) @(posedge clk);
        #3;
        chk("midframe_bit3_low", {31'd0, tx_v[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx",     {31'd0, tx_v[0]},     32'd1);
        chk("abort_tready", {31'd0, tready_v[0]}, 32'd1);
        chk("abort_busy",   {31'd0, busy_v[0]},   32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = frames_seen[0];
        idle_ok = 1;
        repeat (300) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || tready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) idle_ok = 0;
        end
        chk("no_residual_frame", {31'd0, idle_ok}, 32'd1);
        chk("no_residual_count", frames_seen[0] - base, 32'd0);
        chk("abort_hs_edge", hs1 > 0, 32'd1);
        @(posedge clk);
        #1;

        // Randomized traffic across instances with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            g = $urandom_range(0, 2);
            b = 8'($urandom);
            send(g, b);
            repeat ($urandom_range(0, 25)) @(posedge clk);
            #1;
        end
        wait_idle();

        // Every byte value through the no-parity instance.
        base = frames_seen[2];
        for (int i = 0; i < 256; i++) send(2, 8'(i));
        wait_idle();
        chk("all_bytes_count", frames_seen[2] - base, 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
